// File: rtl/sram_ctrl_pkg.sv
// sram_ctrl_pkg: shared types and constants for the SRAM load/store front-end.
//   sram_ctrl_state_t : controller FSM states
//   SZ_*              : request size encodings (3 is illegal)
//   WORD_IDX_W        : width of the macro word index
//   is_misaligned()   : size/offset legality rule shared by the lane logic
package sram_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SETUP   = 3'd1,
        PULSE   = 3'd2,
        CAPTURE = 3'd3,
        RESP    = 3'd4,
        ERR     = 3'd5
    } sram_ctrl_state_t;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    localparam int WORD_IDX_W = 7;

    // A half must sit on an even byte, a word on a word boundary; size 3 is never legal.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
        logic bad;
        case (size)
            SZ_BYTE: bad = 1'b0;
            SZ_HALF: bad = off[0];
            SZ_WORD: bad = (off != 2'd0);
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/sram_lane_align.sv
// sram_lane_align: purely combinational byte-lane logic for the SRAM front-end.
//   Request side (from the incoming request):
//     req_off, req_size, req_wdata -> byte_sel, datain, misaligned
//   Read side (from the latched request and the macro):
//     rd_off, rd_size, rd_unsigned, rd_word -> rd_data (aligned, extended)
module sram_lane_align
    import sram_ctrl_pkg::*;
(
    input  logic [1:0]  req_off,
    input  logic [1:0]  req_size,
    input  logic [31:0] req_wdata,
    output logic [3:0]  byte_sel,
    output logic [31:0] datain,
    output logic        misaligned,
    input  logic [1:0]  rd_off,
    input  logic [1:0]  rd_size,
    input  logic        rd_unsigned,
    input  logic [31:0] rd_word,
    output logic [31:0] rd_data
);

    logic [31:0] rd_shift_s;

    // Lane enables and replicated store data; replication lets the macro pick
    // the right lanes without any shifting of the write data.
    always_comb begin
        byte_sel   = 4'h0;
        datain     = 32'h0000_0000;
        misaligned = is_misaligned(req_size, req_off);
        case (req_size)
            SZ_BYTE: begin
                byte_sel = 4'b0001 << req_off;
                datain   = {4{req_wdata[7:0]}};
            end
            SZ_HALF: begin
                byte_sel = 4'b0011 << req_off;
                datain   = {2{req_wdata[15:0]}};
            end
            SZ_WORD: begin
                byte_sel = 4'hF;
                datain   = req_wdata;
            end
            default: begin
                byte_sel = 4'h0;
                datain   = 32'h0000_0000;
            end
        endcase
    end

    // Right-justify the addressed lane, then sign- or zero-extend by size.
    always_comb begin
        rd_shift_s = rd_word >> {rd_off, 3'b000};
        rd_data    = 32'h0000_0000;
        case (rd_size)
            SZ_BYTE: begin
                if (rd_unsigned) begin
                    rd_data = {24'h00_0000, rd_shift_s[7:0]};
                end else begin
                    rd_data = {{24{rd_shift_s[7]}}, rd_shift_s[7:0]};
                end
            end
            SZ_HALF: begin
                if (rd_unsigned) begin
                    rd_data = {16'h0000, rd_shift_s[15:0]};
                end else begin
                    rd_data = {{16{rd_shift_s[15]}}, rd_shift_s[15:0]};
                end
            end
            SZ_WORD: rd_data = rd_shift_s;
            default: rd_data = 32'h0000_0000;
        endcase
    end

endmodule

// File: rtl/sram_ctrl.sv
// sram_ctrl: load/store front-end for the 128 x 32-bit SRAM macro.
//   Accepts one byte-addressed request at a time (req_valid/req_ready), checks
//   alignment, drives registered word/lane selects, write data and a read or
//   write pulse PULSE_CYCLES long, then returns a one-cycle resp_valid strobe
//   with aligned, extended load data (0 for stores and errors) and resp_err.
//   Ports:
//     clk, rst                 clock, synchronous active-high reset
//     req_*                    core request (valid/ready handshake)
//     resp_valid/rdata/err     completion strobe and result
//     sram_addr_sel/byte_sel   macro word index and lane enables
//     sram_read/write_pulse    macro strobes, never high together
//     sram_datain/dataout      macro write data / read word
module sram_ctrl
    import sram_ctrl_pkg::*;
#(
    parameter int PULSE_CYCLES = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [8:0]            req_addr,
    input  logic [1:0]            req_size,
    input  logic                  req_unsigned,
    input  logic [31:0]           req_wdata,
    output logic                  resp_valid,
    output logic [31:0]           resp_rdata,
    output logic                  resp_err,
    output logic [WORD_IDX_W-1:0] sram_addr_sel,
    output logic [3:0]            sram_byte_sel,
    output logic                  sram_read_pulse,
    output logic                  sram_write_pulse,
    output logic [31:0]           sram_datain,
    input  logic [31:0]           sram_dataout
);

    // The counter holds the number of pulse cycles still to go after the current one.
    localparam logic [3:0] CNT_LOAD = 4'(PULSE_CYCLES - 1);

    sram_ctrl_state_t state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        we_q, we_d;
    logic [1:0]  off_q, off_d;
    logic [1:0]  size_q, size_d;
    logic        uns_q, uns_d;

    logic                  resp_valid_q, resp_valid_d;
    logic                  resp_err_q, resp_err_d;
    logic [31:0]           resp_rdata_q, resp_rdata_d;
    logic [WORD_IDX_W-1:0] addr_sel_q, addr_sel_d;
    logic [3:0]            byte_sel_q, byte_sel_d;
    logic [31:0]           datain_q, datain_d;
    logic                  rd_pulse_q, rd_pulse_d;
    logic                  wr_pulse_q, wr_pulse_d;

    logic [3:0]  lane_byte_sel_s;
    logic [31:0] lane_datain_s;
    logic        lane_misaligned_s;
    logic [31:0] lane_rdata_s;
    logic        accept_ok_s;

    sram_lane_align u_lane (
        .req_off     (req_addr[1:0]),
        .req_size    (req_size),
        .req_wdata   (req_wdata),
        .byte_sel    (lane_byte_sel_s),
        .datain      (lane_datain_s),
        .misaligned  (lane_misaligned_s),
        .rd_off      (off_q),
        .rd_size     (size_q),
        .rd_unsigned (uns_q),
        .rd_word     (sram_dataout),
        .rd_data     (lane_rdata_s)
    );

    assign req_ready = (state_q == IDLE);

    // State, pulse counter and latched request.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            we_q    <= 1'b0;
            off_q   <= 2'd0;
            size_q  <= 2'd0;
            uns_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            off_q   <= off_d;
            size_q  <= size_d;
            uns_q   <= uns_d;
        end
    end

    // Next-state logic, counter sequencing and request latching.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        we_d    = we_q;
        off_d   = off_q;
        size_d  = size_q;
        uns_d   = uns_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    we_d   = req_we;
                    off_d  = req_addr[1:0];
                    size_d = req_size;
                    uns_d  = req_unsigned;
                    if (lane_misaligned_s) begin
                        state_d = ERR;
                    end else begin
                        state_d = SETUP;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            SETUP: begin
                state_d = PULSE;
                cnt_d   = CNT_LOAD;
            end
            PULSE: begin
                if (cnt_q == 4'd0) begin
                    state_d = CAPTURE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            CAPTURE: state_d = RESP;
            RESP:    state_d = IDLE;
            ERR:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign accept_ok_s = (state_q == IDLE) && req_valid && !lane_misaligned_s;

    // Output values for the next cycle, derived from the upcoming state so every
    // output is a flop; macro selects are loaded only for a legal accept and
    // otherwise held, which keeps them stable from SETUP through CAPTURE.
    always_comb begin
        if (accept_ok_s) begin
            addr_sel_d = req_addr[8:2];
            byte_sel_d = lane_byte_sel_s;
            datain_d   = lane_datain_s;
        end else begin
            addr_sel_d = addr_sel_q;
            byte_sel_d = byte_sel_q;
            datain_d   = datain_q;
        end
        rd_pulse_d   = (state_d == PULSE) && !we_q;
        wr_pulse_d   = (state_d == PULSE) && we_q;
        resp_valid_d = (state_d == RESP) || (state_d == ERR);
        resp_err_d   = (state_d == ERR);
        // Loads take the macro word while in CAPTURE and present it in RESP.
        if ((state_d == RESP) && !we_q) begin
            resp_rdata_d = lane_rdata_s;
        end else begin
            resp_rdata_d = 32'h0000_0000;
        end
    end

    // Registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            resp_rdata_q <= 32'h0000_0000;
            addr_sel_q   <= '0;
            byte_sel_q   <= 4'h0;
            datain_q     <= 32'h0000_0000;
            rd_pulse_q   <= 1'b0;
            wr_pulse_q   <= 1'b0;
        end else begin
            resp_valid_q <= resp_valid_d;
            resp_err_q   <= resp_err_d;
            resp_rdata_q <= resp_rdata_d;
            addr_sel_q   <= addr_sel_d;
            byte_sel_q   <= byte_sel_d;
            datain_q     <= datain_d;
            rd_pulse_q   <= rd_pulse_d;
            wr_pulse_q   <= wr_pulse_d;
        end
    end

    assign resp_valid       = resp_valid_q;
    assign resp_err         = resp_err_q;
    assign resp_rdata       = resp_rdata_q;
    assign sram_addr_sel    = addr_sel_q;
    assign sram_byte_sel    = byte_sel_q;
    assign sram_datain      = datain_q;
    assign sram_read_pulse  = rd_pulse_q;
    assign sram_write_pulse = wr_pulse_q;

endmodule

// File: tb/tb_sram_ctrl.sv
// Testbench for sram_ctrl: two instances (PULSE_CYCLES = 2 and 1), each with its
// own macro model, byte-array reference model, scoreboard queue and monitor.
module tb_sram_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests  = 0;
    int n_fail   = 0;
    int done_cnt = 0;
    int cyc      = 0;

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic        err;
        logic        we;
        logic [31:0] rdata;
        int          acc_cyc;
        logic [6:0]  addr_sel;
        logic [3:0]  bsel;
        logic [31:0] din;
    } exp_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    for (genvar g = 0; g < 2; g++) begin : g_dut
        localparam int P = (g == 0) ? 2 : 1;

        logic        rst, req_valid, req_ready, req_we, req_unsigned;
        logic [8:0]  req_addr;
        logic [1:0]  req_size;
        logic [31:0] req_wdata;
        logic        resp_valid, resp_err, rp, wp;
        logic [31:0] resp_rdata, datain;
        logic [31:0] dataout = 32'h0;
        logic [6:0]  addr_sel;
        logic [3:0]  bsel;
        logic [31:0] mem   [128] = '{default: 32'h0};
        logic [7:0]  ref_b [512] = '{default: 8'h00};
        exp_t        q[$];

        sram_ctrl #(.PULSE_CYCLES(P)) u_dut (
            .clk(clk), .rst(rst),
            .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
            .req_addr(req_addr), .req_size(req_size), .req_unsigned(req_unsigned),
            .req_wdata(req_wdata),
            .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
            .sram_addr_sel(addr_sel), .sram_byte_sel(bsel),
            .sram_read_pulse(rp), .sram_write_pulse(wp),
            .sram_datain(datain), .sram_dataout(dataout)
        );

        // Macro model: lane-masked write, registered read word.
        always @(posedge clk) begin
            if (wp) begin
                for (int i = 0; i < 4; i++) begin
                    if (bsel[i]) mem[addr_sel][8*i +: 8] <= datain[8*i +: 8];
                end
            end
            if (rp) dataout <= mem[addr_sel];
        end

        // Monitor: pulse accounting, select stability, response scoreboard.
        initial begin
            int   rcnt;
            int   wcnt;
            exp_t e;
            rcnt = 0;
            wcnt = 0;
            forever begin
                @(negedge clk);
                if (rst) begin
                    rcnt = 0;
                    wcnt = 0;
                end else begin
                    if (rp || wp) begin
                        rcnt += int'(rp);
                        wcnt += int'(wp);
                        check($sformatf("g%0d pulse_exclusive", g), {31'b0, rp & wp}, 32'd0);
                        if (q.size() > 0) begin
                            check($sformatf("g%0d addr_sel_during_pulse", g), {25'b0, addr_sel}, {25'b0, q[0].addr_sel});
                            check($sformatf("g%0d byte_sel_during_pulse", g), {28'b0, bsel}, {28'b0, q[0].bsel});
                            check($sformatf("g%0d datain_during_pulse", g), datain, q[0].din);
                        end
                    end
                    if (resp_valid) begin
                        if (q.size() == 0) begin
                            check($sformatf("g%0d unexpected_resp", g), 32'd1, 32'd0);
                        end else begin
                            e = q.pop_front();
                            check($sformatf("g%0d resp_err", g), {31'b0, resp_err}, {31'b0, e.err});
                            check($sformatf("g%0d resp_rdata", g), resp_rdata, e.rdata);
                            check($sformatf("g%0d latency", g), cyc - e.acc_cyc, e.err ? 0 : P + 2);
                            check($sformatf("g%0d read_pulse_cycles", g), rcnt, (e.err || e.we) ? 0 : P);
                            check($sformatf("g%0d write_pulse_cycles", g), wcnt, (!e.err && e.we) ? P : 0);
                            rcnt = 0;
                            wcnt = 0;
                        end
                    end
                end
            end
        end

        // Issue one request, computing its expected outcome from the byte model.
        task automatic do_req(input logic we, input logic [8:0] addr, input logic [1:0] size,
                              input logic uns, input logic [31:0] wdata);
            exp_t        e;
            int          n;
            int          budget;
            logic [31:0] v;
            e.we       = we;
            e.err      = (size == 2'd3) || (size == 2'd1 && addr[0]) || (size == 2'd2 && addr[1:0] != 2'd0);
            e.rdata    = 32'h0;
            e.addr_sel = addr[8:2];
            e.bsel     = 4'h0;
            e.din      = 32'h0;
            e.acc_cyc  = 0;
            n = 1 << size;
            if (!e.err) begin
                for (int i = 0; i < n; i++) e.bsel[int'(addr[1:0]) + i] = 1'b1;
                for (int j = 0; j < 4; j++) e.din[8*j +: 8] = wdata[8*(j % n) +: 8];
                if (we) begin
                    for (int i = 0; i < n; i++) ref_b[int'(addr) + i] = wdata[8*i +: 8];
                end else begin
                    v = 32'h0;
                    for (int i = 0; i < n; i++) v[8*i +: 8] = ref_b[int'(addr) + i];
                    if (!uns && n < 4 && v[8*n-1]) begin
                        for (int k = 8*n; k < 32; k++) v[k] = 1'b1;
                    end
                    e.rdata = v;
                end
            end
            req_valid = 1'b1; req_we = we; req_addr = addr;
            req_size = size; req_unsigned = uns; req_wdata = wdata;
            budget = 0;
            while (!req_ready && budget < 100) begin
                @(negedge clk);
                budget++;
            end
            if (!req_ready) begin
                check($sformatf("g%0d accept_timeout", g), 32'd0, 32'd1);
                req_valid = 1'b0;
            end else begin
                e.acc_cyc = cyc + 1;
                q.push_back(e);
                @(negedge clk);
                req_valid = 1'b0;
            end
        endtask

        task automatic wait_idle();
            int budget;
            budget = 0;
            while ((q.size() != 0 || !req_ready) && budget < 100) begin
                @(negedge clk);
                budget++;
            end
            check($sformatf("g%0d drain_timeout", g), {31'b0, (q.size() != 0)}, 32'd0);
        endtask

        // Stimulus.
        initial begin
            int          budget;
            logic [8:0]  a;
            logic [1:0]  sz;
            rst = 1'b1; req_valid = 1'b1; req_we = 1'b1; req_addr = 9'h010;
            req_size = 2'd2; req_unsigned = 1'b0; req_wdata = 32'hFFFF_FFFF;
            repeat (3) @(negedge clk);
            check($sformatf("g%0d reset_ctrl", g), {27'b0, resp_valid, resp_err, rp, wp, req_ready}, 32'h1);
            check($sformatf("g%0d reset_rdata", g), resp_rdata, 32'h0);
            check($sformatf("g%0d reset_sel", g), {21'b0, addr_sel, bsel}, 32'h0);
            check($sformatf("g%0d reset_datain", g), datain, 32'h0);
            rst = 1'b0; req_valid = 1'b0;
            @(negedge clk);
            check($sformatf("g%0d ready_after_reset", g), {31'b0, req_ready}, 32'd1);

            do_req(1'b1, 9'h010, 2'd2, 1'b0, 32'hDEAD_BEEF);
            do_req(1'b0, 9'h010, 2'd2, 1'b0, 32'h0);
            do_req(1'b1, 9'h010, 2'd2, 1'b0, 32'h80FF_7F01);
            do_req(1'b0, 9'h013, 2'd0, 1'b0, 32'h0);
            do_req(1'b0, 9'h013, 2'd0, 1'b1, 32'h0);
            do_req(1'b0, 9'h012, 2'd1, 1'b0, 32'h0);
            do_req(1'b1, 9'h020, 2'd2, 1'b0, 32'h1122_3344);
            do_req(1'b1, 9'h022, 2'd1, 1'b0, 32'h0000_A5C3);
            do_req(1'b0, 9'h020, 2'd2, 1'b0, 32'h0);
            do_req(1'b0, 9'h005, 2'd2, 1'b0, 32'h0);
            do_req(1'b0, 9'h001, 2'd1, 1'b0, 32'h0);
            do_req(1'b1, 9'h008, 2'd3, 1'b0, 32'h0000_1234);
            wait_idle();

            // Reset during the first pulse cycle of a load.
            do_req(1'b0, 9'h010, 2'd2, 1'b0, 32'h0);
            budget = 0;
            while (!rp && budget < 20) begin
                @(negedge clk);
                budget++;
            end
            check($sformatf("g%0d pulse_seen_before_reset", g), {31'b0, rp}, 32'd1);
            rst = 1'b1;
            @(negedge clk);
            check($sformatf("g%0d midop_reset_outputs", g), {28'b0, rp, wp, resp_valid, req_ready}, 32'h1);
            q.delete();
            @(negedge clk);
            rst = 1'b0;
            repeat (3) @(negedge clk);
            do_req(1'b0, 9'h010, 2'd2, 1'b0, 32'h0);
            wait_idle();

            for (int it = 0; it < 60; it++) begin
                sz = 2'($urandom_range(0, 3));
                a  = {3'b000, 6'($urandom)};
                if ($urandom_range(0, 3) != 0) begin
                    if (sz == 2'd1) a[0] = 1'b0;
                    if (sz == 2'd2) a[1:0] = 2'd0;
                end
                do_req(1'($urandom), a, sz, 1'($urandom), $urandom);
            end
            wait_idle();
            done_cnt++;
        end
    end

    initial begin
        int budget;
        budget = 0;
        while (done_cnt < 2 && budget < 20000) begin
            @(negedge clk);
            budget++;
        end
        check("run_timeout", done_cnt, 32'd2);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
